regfile_debug_arbiter: RTL and testbench

Shares the CPU register file's write port and read port 1 between the single-cycle core and a debug host. The block sits between the core's writeback/decode signals and the register file. Normally it passes core signals through unchanged. On a debug request it briefly stalls the core for one access cycle and returns read data to the host over a four-phase req/ack handshake. The core has priority, but a starvation counter bounds how long the debug host waits.

---
 rtl/regfile_debug_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_debug_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_arbiter.sv
// Purpose: shares the register file write port and read port 1 between the core and a debug host.
// Latency: core path is combinational; a debug access acks 2 cycles after PEND entry when the core is idle, or STARVE_LIMIT+2 cycles at worst.
// Backpressure: the core stalls for the single ACCESS cycle; the host holds dbg_req until dbg_ack (four-phase).
module regfile_debug_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              cpu_stall,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [ADDR_W-1:0] rf_readReg1,
    input  logic [DATA_W-1:0] rf_readData1
);

    localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              req_we_q,   req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;

    // State, starvation counter, latched request and read result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic: the core keeps the port until it idles or the host has waited STARVE_LIMIT cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d    = PEND;
                    wait_cnt_d = '0;
                    req_we_d   = dbg_we;
                    req_addr_d = dbg_addr;
                    req_data_d = dbg_wdata;
                end
            end
            PEND: begin
                if (!dbg_req) begin
                    state_d = IDLE;
                end else if (!cpu_wr_en || (wait_cnt_q == CNT_LIMIT)) begin
                    state_d = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ACCESS: begin
                // A write leaves the previous read result in place.
                if (!req_we_q) begin
                    rdata_d = rf_readData1;
                end
                state_d = ACK;
            end
            ACK: begin
                if (!dbg_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port mux: core passes through except in ACCESS; writes to r0 are dropped and reset blocks any write.
    always_comb begin
        rf_regWrite  = cpu_wr_en;
        rf_writeReg  = cpu_wr_addr;
        rf_writeData = cpu_wr_data;
        rf_readReg1  = cpu_rd_addr;
        if (state_q == ACCESS) begin
            rf_regWrite  = req_we_q && (req_addr_q != '0);
            rf_writeReg  = req_addr_q;
            rf_writeData = req_data_q;
            rf_readReg1  = req_addr_q;
        end
        if (reset) begin
            rf_regWrite = 1'b0;
        end
    end

    // Handshake outputs decode straight from registered state so they hold steady for the whole cycle.
    assign cpu_stall = (state_q == ACCESS);
    assign dbg_ack   = (state_q == ACK);
    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
module tb_regfile_debug_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_wr_en;
    logic [4:0]  cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic [4:0]  cpu_rd_addr;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        cpu_stall;
    logic        rf_regWrite;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [4:0]  rf_readReg1;
    logic [31:0] rf_readData1;

    always #5 clk = ~clk;

    regfile_debug_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_wr_en(cpu_wr_en),
        .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_addr(cpu_rd_addr),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .cpu_stall(cpu_stall),
        .rf_regWrite(rf_regWrite),
        .rf_writeReg(rf_writeReg),
        .rf_writeData(rf_writeData),
        .rf_readReg1(rf_readReg1),
        .rf_readData1(rf_readData1)
    );

    // Register file environment: negedge write, combinational read, r0 hard-wired to zero, rN initialised to N.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    end
    always @(negedge clk) begin
        if (rf_regWrite && rf_writeReg != 5'd0) mem[rf_writeReg] = rf_writeData;
    end
    assign rf_readData1 = (rf_readReg1 == 5'd0) ? 32'd0 : mem[rf_readReg1];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] rdata_model = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One four-phase host access; exp_lat counts edges from driving dbg_req to seeing dbg_ack.
    task automatic dbg_access(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd, input int exp_lat, input int hold);
        int lat;
        int stalls;
        if (!we) rdata_model = exp_rd;
        exp_q.push_back(rdata_model);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        lat = 0; stalls = 0;
        do begin
            tick();
            lat++;
            if (cpu_stall) begin
                stalls++;
                chk("acc_rd_addr", 64'(rf_readReg1), 64'(a));
                chk("acc_regwrite", 64'(rf_regWrite), 64'(we && (a != 5'd0)));
                if (we && a != 5'd0) begin
                    chk("acc_wr_addr", 64'(rf_writeReg), 64'(a));
                    chk("acc_wr_data", 64'(rf_writeData), 64'(d));
                end
            end
        end while (!dbg_ack && lat < 40);
        chk("ack_seen", 64'(dbg_ack), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("stall_cycles", 64'(stalls), 64'd1);
        chk("rdata", 64'(dbg_rdata), 64'(exp_q.pop_front()));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_ack", 64'(dbg_ack), 64'd1);
            chk("hold_no_stall", 64'(cpu_stall), 64'd0);
        end
        dbg_req = 1'b0;
        tick();
        chk("ack_drop", 64'(dbg_ack), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_wr_en = 1'b1; cpu_wr_addr = 5'd2; cpu_wr_data = 32'hABCD; cpu_rd_addr = 5'd1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        tick(); tick();
        chk("rst_regwrite", 64'(rf_regWrite), 64'd0);
        chk("rst_wr_addr", 64'(rf_writeReg), 64'd2);
        chk("rst_ack", 64'(dbg_ack), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_rdata", 64'(dbg_rdata), 64'd0);
        reset = 1'b0; cpu_wr_en = 1'b0;
        tick();

        // Idle read of r5.
        dbg_access(1'b0, 5'd5, 32'd0, 32'h5, 3, 0);

        // Write then read back r3, then the core reads it.
        dbg_access(1'b1, 5'd3, 32'hDEADBEEF, 32'd0, 3, 0);
        dbg_access(1'b0, 5'd3, 32'd0, 32'hDEADBEEF, 3, 0);
        cpu_rd_addr = 5'd3;
        #1;
        chk("core_read_r3", 64'(rf_readData1), 64'hDEADBEEF);

        // Starvation: the core writes every cycle.
        cpu_wr_en = 1'b1; cpu_wr_addr = 5'd9; cpu_wr_data = 32'h77;
        dbg_access(1'b0, 5'd4, 32'd0, 32'h4, LIMIT + 3, 0);
        chk("core_write_resumes", 64'(rf_regWrite), 64'd1);
        chk("core_write_data", 64'(rf_writeData), 64'h77);
        tick();
        chk("r9_landed", 64'(mem[9]), 64'h77);
        cpu_wr_en = 1'b0;

        // r0 protection.
        dbg_access(1'b1, 5'd0, 32'hFFFFFFFF, 32'd0, 3, 0);
        dbg_access(1'b0, 5'd0, 32'd0, 32'h0, 3, 0);

        // Request held after ack: no second access.
        dbg_access(1'b0, 5'd5, 32'd0, 32'h5, 3, 3);

        // Abort in PEND while the core is busy.
        cpu_wr_en = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd6;
        tick();
        chk("abort_pend_stall", 64'(cpu_stall), 64'd0);
        dbg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_ack", 64'(dbg_ack), 64'd0);
            chk("abort_stall", 64'(cpu_stall), 64'd0);
        end
        cpu_wr_en = 1'b0;

        // Reset during the ACCESS of a write to r7.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234;
        tick(); tick();
        chk("rst_acc_stall", 64'(cpu_stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_acc_regwrite", 64'(rf_regWrite), 64'd0);
        tick();
        chk("rst_acc_ack", 64'(dbg_ack), 64'd0);
        chk("rst_acc_stall_off", 64'(cpu_stall), 64'd0);
        chk("rst_acc_rdata", 64'(dbg_rdata), 64'd0);
        reset = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_rst_ack", 64'(dbg_ack), 64'd0);
        end
        chk("r7_unchanged", 64'(mem[7]), 64'd7);
        rdata_model = 32'd0;

        // Pass-through under random core traffic.
        for (int i = 0; i < 100; i++) begin
            cpu_wr_en   = 1'($urandom_range(0, 1));
            cpu_wr_addr = 5'($urandom_range(0, 31));
            cpu_wr_data = $urandom;
            cpu_rd_addr = 5'($urandom_range(0, 31));
            #1;
            chk("pass_through", 64'({rf_regWrite, rf_writeReg, rf_writeData, rf_readReg1}),
                64'({cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr}));
            chk("pass_stall", 64'(cpu_stall), 64'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
